// File: rtl/csr_mach_hpm.sv
// csr_mach_hpm: machine-mode CSR file with mcycle/minstret, NUM_HPM event-driven
// performance counters, mcountinhibit, prioritised interrupts and vectored trap target.
// Optional feature: define CSR_LCOFI_EN for the local counter-overflow interrupt (code 13).
module csr_mach_hpm #(
    parameter int unsigned NUM_HPM   = 4,
    parameter int unsigned CNT_WIDTH = 64,
    parameter int unsigned NUM_EVT   = 8,
    parameter logic [31:0] MTVEC_RST = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rden,
    input  logic [11:0]        raddr,
    output logic [31:0]        rdata,
    input  logic               wren,
    input  logic [11:0]        waddr,
    input  logic [31:0]        wdata,
    input  logic               valid,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               exc,
    input  logic [3:0]         ecause,
    input  logic [31:0]        epc,
    input  logic [31:0]        etval,
    input  logic               mret_in,
    input  logic               irq_sw,
    input  logic               irq_tim,
    input  logic               irq_ext,
    output logic               trap,
    output logic               mret,
    output logic [31:0]        mepc_out,
    output logic [31:0]        mtvec_out
);
    // Counter slot j maps to CSR index j: 0 = mcycle, 1 = (time, absent), 2 = minstret, 3.. = hpm
    localparam int unsigned NC = NUM_HPM + 3;
    localparam int unsigned HW = CNT_WIDTH - 32;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [31:0] INH_MASK = 32'h0000_0005 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
`ifdef CSR_LCOFI_EN
    localparam logic [31:0] MIE_MASK = 32'h0000_2888;
`else
    localparam logic [31:0] MIE_MASK = 32'h0000_0888;
`endif

    // Trap target: vectored only for interrupts when mode is 1, direct otherwise
    function automatic logic [31:0] tvec_f(input logic [31:0] tvec, input logic is_irq, input logic [4:0] code);
        logic [31:0] base;
        base = {tvec[31:2], 2'b00};
        if ((tvec[1:0] == 2'b01) && is_irq) begin
            tvec_f = base + {25'b0, code, 2'b00};
        end else begin
            tvec_f = base;
        end
    endfunction

    logic                 mstat_mie_r, mstat_mpie_r;
    logic [31:0]          mie_r, mip_r, mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r, inhibit_r;
    logic [CNT_WIDTH-1:0] cnt_r [NC];
    logic [4:0]           evsel_r [NC];
    logic [NC-1:0]        of_r;
    logic                 trap_r, mret_r;
    logic [31:0]          mtvec_out_r;

    logic                 mstat_mie_nxt_s, mstat_mpie_nxt_s;
    logic [31:0]          mie_nxt_s, mip_nxt_s, mtvec_nxt_s, mscratch_nxt_s, mepc_nxt_s;
    logic [31:0]          mcause_nxt_s, mtval_nxt_s, inhibit_nxt_s;
    logic                 irq_take_s, trap_s;
    logic [3:0]           irq_code_s;
    logic [31:0]          cause_s, evt_pad_s, rdata_s;
    logic [NC-1:0]        wr_lo_s, wr_hi_s, wr_ev_s, inc_s;

    // Arbitrate trap sources: exception, then MEI, MSI, MTI, LCOFI
    always_comb begin
        irq_take_s = 1'b0;
        irq_code_s = 4'd0;
        if (mstat_mie_r) begin
            if (mie_r[11] && mip_r[11]) begin
                irq_take_s = 1'b1; irq_code_s = 4'd11;
            end else if (mie_r[3] && mip_r[3]) begin
                irq_take_s = 1'b1; irq_code_s = 4'd3;
            end else if (mie_r[7] && mip_r[7]) begin
                irq_take_s = 1'b1; irq_code_s = 4'd7;
            end else if (mie_r[13] && mip_r[13]) begin
                irq_take_s = 1'b1; irq_code_s = 4'd13;
            end else begin
                irq_take_s = 1'b0; irq_code_s = 4'd0;
            end
        end else begin
            irq_take_s = 1'b0; irq_code_s = 4'd0;
        end
        trap_s  = exc | irq_take_s;
        cause_s = exc ? {28'b0, ecause} : {1'b1, 27'b0, irq_code_s};
    end

    // Per-counter write strobes and increment conditions
    always_comb begin
        evt_pad_s = 32'(evt);
        for (int j = 0; j < NC; j++) begin
            wr_lo_s[j] = wren && (j != 1) && (waddr == (12'hB00 + 12'(j)));
            wr_hi_s[j] = wren && (j != 1) && (waddr == (12'hB80 + 12'(j)));
            wr_ev_s[j] = wren && (j >= 3) && (waddr == (12'h320 + 12'(j)));
            if (j == 0) begin
                inc_s[j] = !inhibit_r[0];
            end else if (j == 2) begin
                inc_s[j] = valid && !inhibit_r[2];
            end else if (j >= 3) begin
                inc_s[j] = !inhibit_r[j] && (evsel_r[j] != 5'd0) &&
                           ({27'b0, evsel_r[j]} <= 32'(NUM_EVT)) && evt_pad_s[evsel_r[j] - 5'd1];
            end else begin
                inc_s[j] = 1'b0;
            end
        end
    end

    // Counters and event selectors; a write to either half beats an increment
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int j = 0; j < NC; j++) begin
                cnt_r[j]   <= {CNT_WIDTH{1'b0}};
                evsel_r[j] <= 5'd0;
            end
        end else begin
            for (int j = 0; j < NC; j++) begin
                if (wr_lo_s[j]) begin
                    cnt_r[j][31:0] <= wdata;
                end else if (wr_hi_s[j]) begin
                    cnt_r[j][CNT_WIDTH-1:32] <= wdata[HW-1:0];
                end else if (inc_s[j]) begin
                    cnt_r[j] <= cnt_r[j] + CNT_ONE;
                end else begin
                    cnt_r[j] <= cnt_r[j];
                end
                if (wr_ev_s[j]) begin
                    evsel_r[j] <= wdata[4:0];
                end else begin
                    evsel_r[j] <= evsel_r[j];
                end
            end
        end
    end

`ifdef CSR_LCOFI_EN
    logic [NC-1:0] ovf_s;

    // Detect an hpm counter wrapping to zero while its overflow flag is clear
    always_comb begin
        for (int j = 0; j < NC; j++) begin
            ovf_s[j] = (j >= 3) && inc_s[j] && !wr_lo_s[j] && !wr_hi_s[j] && (&cnt_r[j]) && !of_r[j];
        end
    end

    // Overflow flags: software writable, set by hardware on wrap
    always_ff @(posedge clk) begin
        if (!rst) begin
            of_r <= {NC{1'b0}};
        end else begin
            for (int j = 0; j < NC; j++) begin
                if (wr_ev_s[j]) begin
                    of_r[j] <= wdata[31];
                end else if (ovf_s[j]) begin
                    of_r[j] <= 1'b1;
                end else begin
                    of_r[j] <= of_r[j];
                end
            end
        end
    end
`else
    // No overflow flags without the overflow interrupt
    always_ff @(posedge clk) begin
        of_r <= {NC{1'b0}};
    end
`endif

    // Next state of the scalar CSRs: CSR writes first, trap/mret events override
    always_comb begin
        mstat_mie_nxt_s  = mstat_mie_r;
        mstat_mpie_nxt_s = mstat_mpie_r;
        mie_nxt_s        = mie_r;
        mtvec_nxt_s      = mtvec_r;
        mscratch_nxt_s   = mscratch_r;
        mepc_nxt_s       = mepc_r;
        mcause_nxt_s     = mcause_r;
        mtval_nxt_s      = mtval_r;
        inhibit_nxt_s    = inhibit_r;
        mip_nxt_s        = {20'b0, irq_ext, 3'b0, irq_tim, 3'b0, irq_sw, 3'b0};
`ifdef CSR_LCOFI_EN
        if (wren && (waddr == 12'h344)) begin
            mip_nxt_s[13] = wdata[13] | (|ovf_s);
        end else begin
            mip_nxt_s[13] = mip_r[13] | (|ovf_s);
        end
`endif
        if (wren) begin
            case (waddr)
                12'h300: begin
                    mstat_mie_nxt_s  = wdata[3];
                    mstat_mpie_nxt_s = wdata[7];
                end
                12'h304: mie_nxt_s      = wdata & MIE_MASK;
                12'h305: mtvec_nxt_s    = wdata;
                12'h340: mscratch_nxt_s = wdata;
                12'h341: mepc_nxt_s     = {wdata[31:2], 2'b00};
                12'h342: mcause_nxt_s   = wdata;
                12'h343: mtval_nxt_s    = wdata;
                12'h320: inhibit_nxt_s  = wdata & INH_MASK;
                default: mscratch_nxt_s = mscratch_r;
            endcase
        end else begin
            mscratch_nxt_s = mscratch_r;
        end
        if (trap_s) begin
            mstat_mpie_nxt_s = mstat_mie_r;
            mstat_mie_nxt_s  = 1'b0;
            mepc_nxt_s       = {epc[31:2], 2'b00};
            mtval_nxt_s      = etval;
            mcause_nxt_s     = cause_s;
        end else if (mret_in) begin
            mstat_mie_nxt_s  = mstat_mpie_r;
            mstat_mpie_nxt_s = 1'b1;
        end else begin
            mstat_mie_nxt_s  = mstat_mie_nxt_s;
        end
    end

    // Scalar CSR state and registered trap/mret/target outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            mstat_mie_r  <= 1'b0;
            mstat_mpie_r <= 1'b0;
            mie_r        <= 32'h0;
            mip_r        <= 32'h0;
            mtvec_r      <= MTVEC_RST;
            mscratch_r   <= 32'h0;
            mepc_r       <= 32'h0;
            mcause_r     <= 32'h0;
            mtval_r      <= 32'h0;
            inhibit_r    <= 32'h0;
            trap_r       <= 1'b0;
            mret_r       <= 1'b0;
            mtvec_out_r  <= tvec_f(MTVEC_RST, 1'b0, 5'd0);
        end else begin
            mstat_mie_r  <= mstat_mie_nxt_s;
            mstat_mpie_r <= mstat_mpie_nxt_s;
            mie_r        <= mie_nxt_s;
            mip_r        <= mip_nxt_s;
            mtvec_r      <= mtvec_nxt_s;
            mscratch_r   <= mscratch_nxt_s;
            mepc_r       <= mepc_nxt_s;
            mcause_r     <= mcause_nxt_s;
            mtval_r      <= mtval_nxt_s;
            inhibit_r    <= inhibit_nxt_s;
            trap_r       <= trap_s;
            mret_r       <= mret_in && !trap_s;
            mtvec_out_r  <= tvec_f(mtvec_nxt_s, mcause_nxt_s[31], mcause_nxt_s[4:0]);
        end
    end

    // CSR read mux; unimplemented addresses and idle reads return zero
    always_comb begin
        rdata_s = 32'h0;
        if (rden) begin
            case (raddr)
                12'h300: rdata_s = {19'b0, 2'b11, 3'b0, mstat_mpie_r, 3'b0, mstat_mie_r, 3'b0};
                12'h301: rdata_s = 32'h4000_0100;
                12'h304: rdata_s = mie_r;
                12'h305: rdata_s = mtvec_r;
                12'h340: rdata_s = mscratch_r;
                12'h341: rdata_s = mepc_r;
                12'h342: rdata_s = mcause_r;
                12'h343: rdata_s = mtval_r;
                12'h344: rdata_s = mip_r;
                12'h320: rdata_s = inhibit_r;
                default: rdata_s = 32'h0;
            endcase
            for (int j = 0; j < NC; j++) begin
                if ((j != 1) && (raddr == (12'hB00 + 12'(j)))) begin
                    rdata_s = cnt_r[j][31:0];
                end else if ((j != 1) && (raddr == (12'hB80 + 12'(j)))) begin
                    rdata_s = 32'(cnt_r[j][CNT_WIDTH-1:32]);
                end else if ((j >= 3) && (raddr == (12'h320 + 12'(j)))) begin
                    rdata_s = {of_r[j], 26'b0, evsel_r[j]};
                end else begin
                    rdata_s = rdata_s;
                end
            end
        end else begin
            rdata_s = 32'h0;
        end
    end

    assign rdata     = rdata_s;
    assign trap      = trap_r;
    assign mret      = mret_r;
    assign mepc_out  = mepc_r;
    assign mtvec_out = mtvec_out_r;
endmodule

// File: tb/tb_csr_mach_hpm.sv
// tb_csr_mach_hpm: directed test of csr_mach_hpm with default parameters.
module tb_csr_mach_hpm;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rden = 1'b0;
    logic [11:0] raddr = 12'h0;
    logic [31:0] rdata;
    logic        wren = 1'b0;
    logic [11:0] waddr = 12'h0;
    logic [31:0] wdata = 32'h0;
    logic        valid = 1'b0;
    logic [7:0]  evt = 8'h0;
    logic        exc = 1'b0;
    logic [3:0]  ecause = 4'h0;
    logic [31:0] epc = 32'h0;
    logic [31:0] etval = 32'h0;
    logic        mret_in = 1'b0;
    logic        irq_sw = 1'b0;
    logic        irq_tim = 1'b0;
    logic        irq_ext = 1'b0;
    logic        trap;
    logic        mret;
    logic [31:0] mepc_out;
    logic [31:0] mtvec_out;

    int n_pass  = 0;
    int n_total = 0;

    csr_mach_hpm dut (
        .clk(clk), .rst(rst), .rden(rden), .raddr(raddr), .rdata(rdata),
        .wren(wren), .waddr(waddr), .wdata(wdata), .valid(valid), .evt(evt),
        .exc(exc), .ecause(ecause), .epc(epc), .etval(etval), .mret_in(mret_in),
        .irq_sw(irq_sw), .irq_tim(irq_tim), .irq_ext(irq_ext),
        .trap(trap), .mret(mret), .mepc_out(mepc_out), .mtvec_out(mtvec_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rden  = 1'b1;
        raddr = a;
        #1;
        d    = rdata;
        rden = 1'b0;
        chk(tag, d, exp);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        wren  = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        wren  = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        repeat (3) tick();
        chk("rst_trap", {31'b0, trap}, 32'h0);
        chk("rst_mret", {31'b0, mret}, 32'h0);
        chk("rst_mepc_out", mepc_out, 32'h0);
        chk("rst_mtvec_out", mtvec_out, 32'h0);
        raddr = 12'h301;
        #1;
        d = rdata;
        chk("rden_low_zero", d, 32'h0);
        rst = 1'b1;
        chk_csr("mtvec_rst", 12'h305, 32'h0);
        chk_csr("mcycle_rst", 12'hB00, 32'h0);
        chk_csr("mip_rst", 12'h344, 32'h0);
        repeat (10) tick();
        chk_csr("mcycle_10", 12'hB00, 32'd10);
        chk_csr("mcycleh_10", 12'hB80, 32'h0);
        chk_csr("misa", 12'h301, 32'h4000_0100);
        chk_csr("unimpl", 12'h7C0, 32'h0);
        chk_csr("mstatus_rst", 12'h300, 32'h0000_1800);

        // hpm3 counts evt[1]; inhibit stops it; out-of-range select never counts
        csr_wr(12'h323, 32'd2);
        evt = 8'h02;
        repeat (5) tick();
        evt = 8'h00;
        csr_wr(12'h320, 32'h8);
        evt = 8'h02;
        repeat (3) tick();
        evt = 8'h00;
        csr_wr(12'h324, 32'd9);
        csr_wr(12'h325, 32'd8);
        evt = 8'hFF;
        repeat (2) tick();
        evt = 8'h00;
        chk_csr("hpm3", 12'hB03, 32'd5);
        chk_csr("hpm3h", 12'hB83, 32'd0);
        chk_csr("hpm4_sel9", 12'hB04, 32'd0);
        chk_csr("hpm5_sel8", 12'hB05, 32'd2);
        chk_csr("hpmevent3", 12'h323, 32'd2);
        chk_csr("inhibit", 12'h320, 32'h8);
        csr_wr(12'h320, 32'hFFFF_FFFF);
        chk_csr("inhibit_mask", 12'h320, 32'h0000_007D);
        csr_wr(12'h320, 32'h0);
        csr_wr(12'h326, 32'hFFFF_FFFF);
        chk_csr("hpmevent6_mask", 12'h326, 32'h0000_001F);
        csr_wr(12'h327, 32'd5);
        chk_csr("hpmevent7_absent", 12'h327, 32'h0);

        // mcycle carry across halves and write-beats-increment
        csr_wr(12'hB00, 32'hFFFF_FFFF);
        csr_wr(12'hB80, 32'h0);
        tick();
        chk_csr("mcycle_wrap_lo", 12'hB00, 32'h0);
        chk_csr("mcycle_wrap_hi", 12'hB80, 32'h1);
        csr_wr(12'hB00, 32'h1234_5678);
        chk_csr("mcycle_wr_wins", 12'hB00, 32'h1234_5678);
        chk_csr("mcycleh_held", 12'hB80, 32'h1);
        tick();
        chk_csr("mcycle_after", 12'hB00, 32'h1234_5679);

        valid = 1'b1;
        repeat (3) tick();
        valid = 1'b0;
        chk_csr("minstret", 12'hB02, 32'd3);
        chk_csr("minstreth", 12'hB82, 32'd0);

        csr_wr(12'h341, 32'h1234_5677);
        chk_csr("mepc_align", 12'h341, 32'h1234_5674);
        chk("mepc_out_wr", mepc_out, 32'h1234_5674);

        // Simultaneous MTI and MEI: MEI wins
        csr_wr(12'h304, 32'hFFFF_FFFF);
        chk_csr("mie_mask", 12'h304, 32'h0000_0888);
        csr_wr(12'h300, 32'h8);
        chk_csr("mstatus_mie", 12'h300, 32'h0000_1808);
        irq_tim = 1'b1;
        irq_ext = 1'b1;
        tick();
        chk("irq_trap_early", {31'b0, trap}, 32'h0);
        tick();
        chk("irq_trap", {31'b0, trap}, 32'h1);
        chk_csr("mcause_mei", 12'h342, 32'h8000_000B);
        chk_csr("mstatus_trap", 12'h300, 32'h0000_1880);
        irq_tim = 1'b0;
        irq_ext = 1'b0;
        tick();
        chk("irq_trap_pulse_end", {31'b0, trap}, 32'h0);
        chk_csr("mip_clear", 12'h344, 32'h0);

        // Vectored mtvec for a timer interrupt, direct for an exception
        csr_wr(12'h305, 32'h0000_0101);
        chk_csr("mtvec_wr", 12'h305, 32'h0000_0101);
        irq_tim = 1'b1;
        tick();
        csr_wr(12'h300, 32'h8);
        tick();
        irq_tim = 1'b0;
        chk("mti_trap", {31'b0, trap}, 32'h1);
        chk("mti_vector", mtvec_out, 32'h0000_011C);
        chk_csr("mcause_mti", 12'h342, 32'h8000_0007);
        exc    = 1'b1;
        ecause = 4'd2;
        epc    = 32'h0000_2003;
        etval  = 32'h0000_DEAD;
        tick();
        exc = 1'b0;
        chk("exc_trap", {31'b0, trap}, 32'h1);
        chk("exc_direct", mtvec_out, 32'h0000_0100);
        chk_csr("mcause_exc", 12'h342, 32'h0000_0002);
        chk("exc_mepc", mepc_out, 32'h0000_2000);
        chk_csr("exc_mtval", 12'h343, 32'h0000_DEAD);

        // Exception and mret together: trap wins
        exc     = 1'b1;
        mret_in = 1'b1;
        epc     = 32'h0000_3000;
        tick();
        exc     = 1'b0;
        mret_in = 1'b0;
        chk("both_trap", {31'b0, trap}, 32'h1);
        chk("both_mret", {31'b0, mret}, 32'h0);
        chk("both_mepc", mepc_out, 32'h0000_3000);
        chk_csr("both_mstatus", 12'h300, 32'h0000_1800);
        mret_in = 1'b1;
        tick();
        mret_in = 1'b0;
        chk("mret_pulse", {31'b0, mret}, 32'h1);
        chk("mret_no_trap", {31'b0, trap}, 32'h0);
        chk_csr("mret_mstatus", 12'h300, 32'h0000_1880);
        tick();
        chk("mret_pulse_end", {31'b0, mret}, 32'h0);

        // Reset while a trap is being requested drops it
        exc = 1'b1;
        rst = 1'b0;
        tick();
        exc = 1'b0;
        chk("rst_mid_trap", {31'b0, trap}, 32'h0);
        chk("rst_mid_mepc", mepc_out, 32'h0);
        chk("rst_mid_mtvec_out", mtvec_out, 32'h0);
        rst = 1'b1;
        tick();
        chk_csr("rst_hpmevent3", 12'h323, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
